// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master / one-slave AXI4-Lite arbiter with independent read and write paths.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // master 0
    input  logic [ADDR_W-1:0]     i_m0_axi_awaddr,
    input  logic [2:0]            i_m0_axi_awprot,
    input  logic                  i_m0_axi_awvalid,
    output logic                  o_m0_axi_awready,
    input  logic [DATA_W-1:0]     i_m0_axi_wdata,
    input  logic [DATA_W/8-1:0]   i_m0_axi_wstrb,
    input  logic                  i_m0_axi_wvalid,
    output logic                  o_m0_axi_wready,
    output logic [1:0]            o_m0_axi_bresp,
    output logic                  o_m0_axi_bvalid,
    input  logic                  i_m0_axi_bready,
    input  logic [ADDR_W-1:0]     i_m0_axi_araddr,
    input  logic [2:0]            i_m0_axi_arprot,
    input  logic                  i_m0_axi_arvalid,
    output logic                  o_m0_axi_arready,
    output logic [DATA_W-1:0]     o_m0_axi_rdata,
    output logic [1:0]            o_m0_axi_rresp,
    output logic                  o_m0_axi_rvalid,
    input  logic                  i_m0_axi_rready,
    // master 1
    input  logic [ADDR_W-1:0]     i_m1_axi_awaddr,
    input  logic [2:0]            i_m1_axi_awprot,
    input  logic                  i_m1_axi_awvalid,
    output logic                  o_m1_axi_awready,
    input  logic [DATA_W-1:0]     i_m1_axi_wdata,
    input  logic [DATA_W/8-1:0]   i_m1_axi_wstrb,
    input  logic                  i_m1_axi_wvalid,
    output logic                  o_m1_axi_wready,
    output logic [1:0]            o_m1_axi_bresp,
    output logic                  o_m1_axi_bvalid,
    input  logic                  i_m1_axi_bready,
    input  logic [ADDR_W-1:0]     i_m1_axi_araddr,
    input  logic [2:0]            i_m1_axi_arprot,
    input  logic                  i_m1_axi_arvalid,
    output logic                  o_m1_axi_arready,
    output logic [DATA_W-1:0]     o_m1_axi_rdata,
    output logic [1:0]            o_m1_axi_rresp,
    output logic                  o_m1_axi_rvalid,
    input  logic                  i_m1_axi_rready,
    // downstream slave
    output logic [ADDR_W-1:0]     o_s_axi_awaddr,
    output logic [2:0]            o_s_axi_awprot,
    output logic                  o_s_axi_awvalid,
    input  logic                  i_s_axi_awready,
    output logic [DATA_W-1:0]     o_s_axi_wdata,
    output logic [DATA_W/8-1:0]   o_s_axi_wstrb,
    output logic                  o_s_axi_wvalid,
    input  logic                  i_s_axi_wready,
    input  logic [1:0]            i_s_axi_bresp,
    input  logic                  i_s_axi_bvalid,
    output logic                  o_s_axi_bready,
    output logic [ADDR_W-1:0]     o_s_axi_araddr,
    output logic [2:0]            o_s_axi_arprot,
    output logic                  o_s_axi_arvalid,
    input  logic                  i_s_axi_arready,
    input  logic [DATA_W-1:0]     i_s_axi_rdata,
    input  logic [1:0]            i_s_axi_rresp,
    input  logic                  i_s_axi_rvalid,
    output logic                  o_s_axi_rready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_t;

    rd_state_t r_rd_state;
    rd_state_t w_rd_state_nxt;
    wr_state_t r_wr_state;
    wr_state_t w_wr_state_nxt;
    logic      r_rgnt;
    logic      w_rgnt_nxt;
    logic      r_wgnt;
    logic      w_wgnt_nxt;
    logic      r_aw_done;
    logic      w_aw_done_nxt;
    logic      r_w_done;
    logic      w_w_done_nxt;

    logic      w_rreq;
    logic      w_wreq;
    logic      w_rwin;
    logic      w_wwin;
    logic      w_rd_addr;
    logic      w_rd_data;
    logic      w_wr_addr;
    logic      w_wr_resp;
    logic      w_ar_hs;
    logic      w_r_hs;
    logic      w_aw_hs;
    logic      w_w_hs;
    logic      w_b_hs;

    assign w_rreq = i_m0_axi_arvalid | i_m1_axi_arvalid;
    assign w_wreq = i_m0_axi_awvalid | i_m1_axi_awvalid;

`ifdef AXI_ARB_RR_EN
    logic r_rlast;
    logic r_wlast;

    // On contention the master not granted last time wins.
    assign w_rwin = i_m0_axi_arvalid ? (i_m1_axi_arvalid ? ~r_rlast : 1'b0) : 1'b1;
    assign w_wwin = i_m0_axi_awvalid ? (i_m1_axi_awvalid ? ~r_wlast : 1'b0) : 1'b1;

    // Last-grant pointers, one per path, refreshed on every grant.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rlast <= 1'b0;
            r_wlast <= 1'b0;
        end else begin
            if ((r_rd_state == R_IDLE) && w_rreq) begin
                r_rlast <= w_rwin;
            end
            if ((r_wr_state == W_IDLE) && w_wreq) begin
                r_wlast <= w_wwin;
            end
        end
    end
`else
    assign w_rwin = ~i_m0_axi_arvalid;
    assign w_wwin = ~i_m0_axi_awvalid;
`endif

    assign w_rd_addr = (r_rd_state == R_ADDR);
    assign w_rd_data = (r_rd_state == R_DATA);
    assign w_wr_addr = (r_wr_state == W_ADDR);
    assign w_wr_resp = (r_wr_state == W_RESP);

    // Read path forwarding
    assign o_s_axi_araddr   = r_rgnt ? i_m1_axi_araddr : i_m0_axi_araddr;
    assign o_s_axi_arprot   = r_rgnt ? i_m1_axi_arprot : i_m0_axi_arprot;
    assign o_s_axi_arvalid  = w_rd_addr & (r_rgnt ? i_m1_axi_arvalid : i_m0_axi_arvalid);
    assign o_m0_axi_arready = w_rd_addr & ~r_rgnt & i_s_axi_arready;
    assign o_m1_axi_arready = w_rd_addr &  r_rgnt & i_s_axi_arready;
    assign o_s_axi_rready   = w_rd_data & (r_rgnt ? i_m1_axi_rready : i_m0_axi_rready);
    assign o_m0_axi_rvalid  = w_rd_data & ~r_rgnt & i_s_axi_rvalid;
    assign o_m1_axi_rvalid  = w_rd_data &  r_rgnt & i_s_axi_rvalid;
    assign o_m0_axi_rdata   = i_s_axi_rdata;
    assign o_m1_axi_rdata   = i_s_axi_rdata;
    assign o_m0_axi_rresp   = i_s_axi_rresp;
    assign o_m1_axi_rresp   = i_s_axi_rresp;
    assign w_ar_hs          = o_s_axi_arvalid & i_s_axi_arready;
    assign w_r_hs           = i_s_axi_rvalid & o_s_axi_rready;

    // Write path forwarding; each channel's valid is masked once it has handshaken.
    assign o_s_axi_awaddr   = r_wgnt ? i_m1_axi_awaddr : i_m0_axi_awaddr;
    assign o_s_axi_awprot   = r_wgnt ? i_m1_axi_awprot : i_m0_axi_awprot;
    assign o_s_axi_wdata    = r_wgnt ? i_m1_axi_wdata  : i_m0_axi_wdata;
    assign o_s_axi_wstrb    = r_wgnt ? i_m1_axi_wstrb  : i_m0_axi_wstrb;
    assign o_s_axi_awvalid  = w_wr_addr & ~r_aw_done & (r_wgnt ? i_m1_axi_awvalid : i_m0_axi_awvalid);
    assign o_s_axi_wvalid   = w_wr_addr & ~r_w_done  & (r_wgnt ? i_m1_axi_wvalid  : i_m0_axi_wvalid);
    assign o_m0_axi_awready = w_wr_addr & ~r_aw_done & ~r_wgnt & i_s_axi_awready;
    assign o_m1_axi_awready = w_wr_addr & ~r_aw_done &  r_wgnt & i_s_axi_awready;
    assign o_m0_axi_wready  = w_wr_addr & ~r_w_done  & ~r_wgnt & i_s_axi_wready;
    assign o_m1_axi_wready  = w_wr_addr & ~r_w_done  &  r_wgnt & i_s_axi_wready;
    assign o_s_axi_bready   = w_wr_resp & (r_wgnt ? i_m1_axi_bready : i_m0_axi_bready);
    assign o_m0_axi_bvalid  = w_wr_resp & ~r_wgnt & i_s_axi_bvalid;
    assign o_m1_axi_bvalid  = w_wr_resp &  r_wgnt & i_s_axi_bvalid;
    assign o_m0_axi_bresp   = i_s_axi_bresp;
    assign o_m1_axi_bresp   = i_s_axi_bresp;
    assign w_aw_hs          = o_s_axi_awvalid & i_s_axi_awready;
    assign w_w_hs           = o_s_axi_wvalid & i_s_axi_wready;
    assign w_b_hs           = i_s_axi_bvalid & o_s_axi_bready;

    // Read FSM next-state and grant selection.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rgnt_nxt     = r_rgnt;
        case (r_rd_state)
            R_IDLE: begin
                if (w_rreq) begin
                    w_rgnt_nxt     = w_rwin;
                    w_rd_state_nxt = R_ADDR;
                end else begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            R_ADDR: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = R_DATA;
                end else begin
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_rd_state_nxt = R_IDLE;
                end else begin
                    w_rd_state_nxt = R_DATA;
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Write FSM next-state, grant selection and AW/W completion tracking.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wgnt_nxt     = r_wgnt;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        case (r_wr_state)
            W_IDLE: begin
                if (w_wreq) begin
                    w_wgnt_nxt     = w_wwin;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                    w_wr_state_nxt = W_ADDR;
                end else begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            W_ADDR: begin
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_wr_state_nxt = W_RESP;
                end else begin
                    w_wr_state_nxt = W_ADDR;
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_state_nxt = W_IDLE;
                end else begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
    end

    // State, grant and done-flag registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
            r_rgnt     <= 1'b0;
            r_wgnt     <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_rgnt     <= w_rgnt_nxt;
            r_wgnt     <= w_wgnt_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: table-driven read vectors plus write/reset sequences.
module tb_axi_lite_arbiter_2to1;

    localparam logic [31:0] A0 = 32'h0001_0004;
    localparam logic [31:0] A1 = 32'h0002_0008;
    localparam logic [31:0] WA0 = 32'h0000_1000;
    localparam logic [31:0] WA1 = 32'h0000_2000;
`ifdef AXI_ARB_RR_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic aclk = 1'b0;
    logic aresetn;
    logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, m0_araddr, m1_araddr;
    logic [2:0]  m0_awprot, m1_awprot, m0_arprot, m1_arprot;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid, m0_bready, m1_bready;
    logic m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
    logic m0_arready, m1_arready, m0_rvalid, m1_rvalid;
    logic [1:0]  m0_bresp, m1_bresp, m0_rresp, m1_rresp;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_lite_arbiter_2to1 dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_m0_axi_awaddr(m0_awaddr), .i_m0_axi_awprot(m0_awprot), .i_m0_axi_awvalid(m0_awvalid), .o_m0_axi_awready(m0_awready),
        .i_m0_axi_wdata(m0_wdata), .i_m0_axi_wstrb(m0_wstrb), .i_m0_axi_wvalid(m0_wvalid), .o_m0_axi_wready(m0_wready),
        .o_m0_axi_bresp(m0_bresp), .o_m0_axi_bvalid(m0_bvalid), .i_m0_axi_bready(m0_bready),
        .i_m0_axi_araddr(m0_araddr), .i_m0_axi_arprot(m0_arprot), .i_m0_axi_arvalid(m0_arvalid), .o_m0_axi_arready(m0_arready),
        .o_m0_axi_rdata(m0_rdata), .o_m0_axi_rresp(m0_rresp), .o_m0_axi_rvalid(m0_rvalid), .i_m0_axi_rready(m0_rready),
        .i_m1_axi_awaddr(m1_awaddr), .i_m1_axi_awprot(m1_awprot), .i_m1_axi_awvalid(m1_awvalid), .o_m1_axi_awready(m1_awready),
        .i_m1_axi_wdata(m1_wdata), .i_m1_axi_wstrb(m1_wstrb), .i_m1_axi_wvalid(m1_wvalid), .o_m1_axi_wready(m1_wready),
        .o_m1_axi_bresp(m1_bresp), .o_m1_axi_bvalid(m1_bvalid), .i_m1_axi_bready(m1_bready),
        .i_m1_axi_araddr(m1_araddr), .i_m1_axi_arprot(m1_arprot), .i_m1_axi_arvalid(m1_arvalid), .o_m1_axi_arready(m1_arready),
        .o_m1_axi_rdata(m1_rdata), .o_m1_axi_rresp(m1_rresp), .o_m1_axi_rvalid(m1_rvalid), .i_m1_axi_rready(m1_rready),
        .o_s_axi_awaddr(s_awaddr), .o_s_axi_awprot(s_awprot), .o_s_axi_awvalid(s_awvalid), .i_s_axi_awready(s_awready),
        .o_s_axi_wdata(s_wdata), .o_s_axi_wstrb(s_wstrb), .o_s_axi_wvalid(s_wvalid), .i_s_axi_wready(s_wready),
        .i_s_axi_bresp(s_bresp), .i_s_axi_bvalid(s_bvalid), .o_s_axi_bready(s_bready),
        .o_s_axi_araddr(s_araddr), .o_s_axi_arprot(s_arprot), .o_s_axi_arvalid(s_arvalid), .i_s_axi_arready(s_arready),
        .i_s_axi_rdata(s_rdata), .i_s_axi_rresp(s_rresp), .i_s_axi_rvalid(s_rvalid), .o_s_axi_rready(s_rready)
    );

    typedef struct {
        bit m0_arv, m1_arv, s_arr, s_rv, m0_rr, m1_rr;
        bit e_s_arv, e_m0_arr, e_m1_arr, e_s_rr, e_m0_rv, e_m1_rv, e_gnt;
    } rd_vec_t;

    rd_vec_t rv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr();
        m0_awvalid = 1'b0; m1_awvalid = 1'b0; m0_wvalid = 1'b0; m1_wvalid = 1'b0;
        m0_bready = 1'b0; m1_bready = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready = 1'b0; m1_rready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
    endtask

    initial begin
        // Cycle-by-cycle read vectors: single m0 read, stray rvalid in idle, then contention.
        rv[0]  = '{0,0,0,0,0,0,  0,0,0,0,0,0,0};
        rv[1]  = '{1,0,0,0,0,0,  0,0,0,0,0,0,0};
        rv[2]  = '{1,0,1,0,0,0,  1,1,0,0,0,0,0};
        rv[3]  = '{0,0,0,1,1,0,  0,0,0,1,1,0,0};
        rv[4]  = '{0,0,0,1,1,1,  0,0,0,0,0,0,0};
        rv[5]  = '{1,1,0,0,0,0,  0,0,0,0,0,0,0};
        rv[6]  = '{1,1,0,0,0,0,  1,0,0,0,0,0,FW};
        rv[7]  = '{1,1,1,0,0,0,  1,!FW,FW,0,0,0,FW};
        rv[8]  = '{FW,!FW,0,1,1,1, 0,0,0,1,!FW,FW,FW};
        rv[9]  = '{FW,!FW,0,0,0,0, 0,0,0,0,0,0,0};
        rv[10] = '{FW,!FW,1,0,0,0, 1,FW,!FW,0,0,0,!FW};
        rv[11] = '{0,0,0,1,1,1,  0,0,0,1,FW,!FW,!FW};

        m0_awaddr = WA0; m1_awaddr = WA1; m0_araddr = A0; m1_araddr = A1;
        m0_awprot = 3'd1; m1_awprot = 3'd2; m0_arprot = 3'd3; m1_arprot = 3'd4;
        m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000; m0_wstrb = 4'hF; m1_wstrb = 4'h3;
        s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; s_bresp = 2'b00;
        clr();
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        #1;
        chk("rst_s_awvalid", {31'd0, s_awvalid}, 32'd0);
        chk("rst_s_wvalid",  {31'd0, s_wvalid},  32'd0);
        chk("rst_s_bready",  {31'd0, s_bready},  32'd0);
        chk("rst_m_bvalid",  {30'd0, m1_bvalid, m0_bvalid}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            m0_arvalid = rv[i].m0_arv; m1_arvalid = rv[i].m1_arv; s_arready = rv[i].s_arr;
            s_rvalid = rv[i].s_rv; m0_rready = rv[i].m0_rr; m1_rready = rv[i].m1_rr;
            #1;
            chk($sformatf("rd%0d_s_arvalid", i), {31'd0, s_arvalid}, {31'd0, rv[i].e_s_arv});
            chk($sformatf("rd%0d_m0_arready", i), {31'd0, m0_arready}, {31'd0, rv[i].e_m0_arr});
            chk($sformatf("rd%0d_m1_arready", i), {31'd0, m1_arready}, {31'd0, rv[i].e_m1_arr});
            chk($sformatf("rd%0d_s_rready", i), {31'd0, s_rready}, {31'd0, rv[i].e_s_rr});
            chk($sformatf("rd%0d_m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, rv[i].e_m0_rv});
            chk($sformatf("rd%0d_m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, rv[i].e_m1_rv});
            if (rv[i].e_s_arv) chk($sformatf("rd%0d_araddr", i), s_araddr, rv[i].e_gnt ? A1 : A0);
            if (rv[i].e_m0_rv) chk($sformatf("rd%0d_m0_rdata", i), m0_rdata, 32'hDEAD_BEEF);
            if (rv[i].e_m1_rv) chk($sformatf("rd%0d_m1_rdata", i), m1_rdata, 32'hDEAD_BEEF);
            tick();
        end
        clr();

`ifdef AXI_ARB_RR_EN
        // m0 was granted last, so a fresh contention goes to m1.
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; tick();
        s_arready = 1'b1; #1;
        chk("rr2_araddr", s_araddr, A1);
        chk("rr2_m1_arready", {31'd0, m1_arready}, 32'd1);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1; tick();
        m0_arvalid = 1'b0; s_rvalid = 1'b0; m1_rready = 1'b0; tick();
        s_arready = 1'b1; m0_arvalid = 1'b1; tick();
        m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1; tick();
        clr();
`endif

        // Write with W accepted two cycles ahead of AW.
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; #1;
        chk("wa0_s_awvalid", {31'd0, s_awvalid}, 32'd0);
        tick();
        s_wready = 1'b1; #1;
        chk("wa1_s_wvalid", {31'd0, s_wvalid}, 32'd1);
        chk("wa1_m0_wready", {31'd0, m0_wready}, 32'd1);
        chk("wa1_m0_awready", {31'd0, m0_awready}, 32'd0);
        chk("wa1_wdata", s_wdata, 32'h1111_0000);
        tick();
        s_bvalid = 1'b1; m0_bready = 1'b1; #1;
        chk("wa2_s_wvalid_gated", {31'd0, s_wvalid}, 32'd0);
        chk("wa2_m0_wready", {31'd0, m0_wready}, 32'd0);
        chk("wa2_s_awvalid", {31'd0, s_awvalid}, 32'd1);
        chk("wa2_s_bready_ignored", {31'd0, s_bready}, 32'd0);
        chk("wa2_m0_bvalid_ignored", {31'd0, m0_bvalid}, 32'd0);
        tick();
        s_bvalid = 1'b0; s_awready = 1'b1; #1;
        chk("wa3_m0_awready", {31'd0, m0_awready}, 32'd1);
        chk("wa3_awaddr", s_awaddr, WA0);
        chk("wa3_s_wvalid", {31'd0, s_wvalid}, 32'd0);
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b10; #1;
        chk("wa4_m0_bvalid", {31'd0, m0_bvalid}, 32'd1);
        chk("wa4_m0_bresp", {30'd0, m0_bresp}, 32'd2);
        chk("wa4_m1_bvalid", {31'd0, m1_bvalid}, 32'd0);
        chk("wa4_s_bready", {31'd0, s_bready}, 32'd1);
        tick();
        #1;
        chk("wa5_m0_bvalid_idle", {31'd0, m0_bvalid}, 32'd0);
        chk("wa5_s_awvalid_idle", {31'd0, s_awvalid}, 32'd0);
        clr(); s_bresp = 2'b00;

        // Same-cycle AW and W from m1: three-cycle write.
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; tick();
        s_awready = 1'b1; s_wready = 1'b1; #1;
        chk("wb1_m1_awready", {31'd0, m1_awready}, 32'd1);
        chk("wb1_m1_wready", {31'd0, m1_wready}, 32'd1);
        chk("wb1_m0_awready", {31'd0, m0_awready}, 32'd0);
        chk("wb1_awaddr", s_awaddr, WA1);
        chk("wb1_wstrb", {28'd0, s_wstrb}, 32'h3);
        tick();
        clr(); s_bvalid = 1'b1; m1_bready = 1'b1; #1;
        chk("wb2_m1_bvalid", {31'd0, m1_bvalid}, 32'd1);
        chk("wb2_s_bready", {31'd0, s_bready}, 32'd1);
        tick();
        clr();

        // m0 write concurrent with m1 read.
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; m1_arvalid = 1'b1; tick();
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; #1;
        chk("cc1_m0_awready", {31'd0, m0_awready}, 32'd1);
        chk("cc1_m1_arready", {31'd0, m1_arready}, 32'd1);
        chk("cc1_araddr", s_araddr, A1);
        tick();
        clr(); s_bvalid = 1'b1; s_rvalid = 1'b1; m0_bready = 1'b1; m1_rready = 1'b1; #1;
        chk("cc2_m0_bvalid", {31'd0, m0_bvalid}, 32'd1);
        chk("cc2_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
        chk("cc2_cross", {30'd0, m1_bvalid, m0_rvalid}, 32'd0);
        tick();
        clr();

        // Reset in R_DATA, then a clean m1 read.
        m0_arvalid = 1'b1; tick();
        s_arready = 1'b1; tick();
        clr(); aresetn = 1'b0; tick();
        aresetn = 1'b1; s_rvalid = 1'b1; m0_rready = 1'b1; m1_arvalid = 1'b1; #1;
        chk("rs_s_rready", {31'd0, s_rready}, 32'd0);
        chk("rs_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rs_s_arvalid", {31'd0, s_arvalid}, 32'd0);
        tick();
        s_rvalid = 1'b0; s_arready = 1'b1; #1;
        chk("rs_m1_arready", {31'd0, m1_arready}, 32'd1);
        chk("rs_araddr", s_araddr, A1);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
        chk("rs_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
        chk("rs_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        tick();
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
